// File: rtl/checker_pkg.sv
// Shared types for the store-stream checker: FSM states, failure codes and
// the expected-store table entry.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_DATA    = 2'b01,
    FC_ADDR    = 2'b10,
    FC_TIMEOUT = 2'b11
  } fail_code_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } exp_entry_t;

endpackage

// File: rtl/exp_table.sv
// Expected-store table: DEPTH entries filled in order, read combinationally
// by index. Tracks how many entries are loaded and flags load attempts made
// while the table is already full.
module exp_table
  import checker_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  exp_entry_t    wr_entry,
  input  logic [IW-1:0] rd_idx,
  output exp_entry_t    rd_entry,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          load_ovf
);

  exp_entry_t mem [DEPTH];

  assign full     = (count == CW'(DEPTH));
  assign rd_entry = mem[rd_idx];

  // Entry count and sticky overflow flag; a write into a full table is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      load_ovf <= 1'b0;
    end else if (wr) begin
      if (full) load_ovf <= 1'b1;
      else      count    <= count + CW'(1);
    end
  end

  // Table storage; contents are don't-care until loaded, so no reset.
  always_ff @(posedge clk) begin
    if (wr && !full) mem[count[IW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/store_stream_checker.sv
// Monitors the data-memory write stream of the single-cycle MIPS core and
// compares each store, in order, against a preloaded table of expected
// (address, data) pairs. Produces a registered pass/fail verdict with the
// failing entry and store captured.
//
// Interface semantics: there is no backpressure anywhere. exp_wr, start and
// memwrite are single-cycle qualifiers sampled on the rising edge; the data
// buses that accompany them (exp_adr/exp_data, dataadr/writedata) are only
// meaningful in a cycle where their qualifier is high. exp_wr is accepted
// only in IDLE; memwrite is only examined in RUN; start only acts in IDLE.
// dbg_state and dbg_count expose the FSM state and loaded-entry count.
module store_stream_checker
  import checker_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter bit STRICT  = 1'b1,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1,
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          exp_wr,
  input  logic [31:0]   exp_adr,
  input  logic [31:0]   exp_data,
  input  logic          start,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [IW-1:0] fail_idx,
  output logic [31:0]   fail_adr,
  output logic [31:0]   fail_data,
  output logic [CW-1:0] match_cnt,
  output logic          load_ovf,
  output state_t        dbg_state,
  output logic [CW-1:0] dbg_count
);

  state_t        state;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;

  exp_entry_t    cur;
  logic [CW-1:0] count;
  logic          full;
  logic          tbl_wr;
  logic [CW-1:0] start_count;
  logic          adr_hit;
  logic          data_hit;
  logic          last;
  logic          tmo;

  // Loads are only honoured while idle; start sees an entry written in the
  // same cycle.
  assign tbl_wr      = exp_wr && (state == IDLE);
  assign start_count = count + CW'(tbl_wr && !full);

  assign adr_hit  = memwrite && (dataadr == cur.adr);
  assign data_hit = (writedata == cur.data);
  assign last     = (CW'(idx) == count - CW'(1));
  assign tmo      = (timer == TW'(TIMEOUT - 1));

  assign dbg_state = state;
  assign dbg_count = count;

  exp_table #(.DEPTH(DEPTH)) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr       (tbl_wr),
    .wr_entry ('{adr: exp_adr, data: exp_data}),
    .rd_idx   (idx),
    .rd_entry (cur),
    .count    (count),
    .full     (full),
    .load_ovf (load_ovf)
  );

  // Checker FSM with timer, match counter and failure capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      timer     <= '0;
      match_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_idx  <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (start_count == '0) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              idx   <= '0;
              timer <= '0;
            end
          end
        end
        RUN: begin
          if (adr_hit && data_hit) begin
            // A match beats a timeout landing on the same edge.
            match_cnt <= match_cnt + CW'(1);
            timer     <= '0;
            idx       <= idx + IW'(1);
            if (last) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else if (adr_hit) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_DATA;
            fail_idx  <= idx;
            fail_adr  <= dataadr;
            fail_data <= writedata;
          end else if (memwrite && STRICT) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_ADDR;
            fail_idx  <= idx;
            fail_adr  <= dataadr;
            fail_data <= writedata;
          end else if (tmo) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_TIMEOUT;
            fail_idx  <= idx;
            fail_adr  <= '0;
            fail_data <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ; // PASS and FAIL hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_store_stream_checker.sv
// Bench for store_stream_checker: a strict and a lenient instance share one
// stimulus stream and are scored against a table-walking reference model.
module tb_store_stream_checker;
  import checker_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(DEPTH);
  localparam int CW      = IW + 1;
  localparam int MAXC    = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        memwrite, exp_wr, start;
  logic [31:0] dataadr, writedata, exp_adr, exp_data;

  logic [1:0]    done_v, pass_v, ovf_v;
  logic [1:0]    fc_v   [2];
  logic [IW-1:0] fidx_v [2];
  logic [31:0]   fadr_v [2];
  logic [31:0]   fdata_v[2];
  logic [CW-1:0] mc_v   [2];
  logic [CW-1:0] cnt_v  [2];
  state_t        st_v   [2];

  // index 0: lenient (STRICT=0), index 1: strict (STRICT=1)
  store_stream_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1'b0)) dut_loose (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_wr(exp_wr), .exp_adr(exp_adr), .exp_data(exp_data), .start(start),
    .done(done_v[0]), .pass(pass_v[0]), .fail_code(fc_v[0]), .fail_idx(fidx_v[0]),
    .fail_adr(fadr_v[0]), .fail_data(fdata_v[0]), .match_cnt(mc_v[0]), .load_ovf(ovf_v[0]),
    .dbg_state(st_v[0]), .dbg_count(cnt_v[0]));

  store_stream_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1'b1)) dut_strict (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_wr(exp_wr), .exp_adr(exp_adr), .exp_data(exp_data), .start(start),
    .done(done_v[1]), .pass(pass_v[1]), .fail_code(fc_v[1]), .fail_idx(fidx_v[1]),
    .fail_adr(fadr_v[1]), .fail_data(fdata_v[1]), .match_cnt(mc_v[1]), .load_ovf(ovf_v[1]),
    .dbg_state(st_v[1]), .dbg_count(cnt_v[1]));

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] load_q[$];  // entries to drive on exp_wr
  logic [64:0] st_q[$];    // per-cycle {memwrite, adr, data} during the run
  logic [63:0] exp_q[$];   // table as the model sees it

  bit          m_run[2], m_done[2], m_pass[2], m_ovf;
  int          m_idx[2], m_since[2], m_mc[2], m_cyc[2], m_fidx[2], d_cyc[2];
  logic [1:0]  m_fc[2];
  logic [31:0] m_fadr[2], m_fdata[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string mname(input int m);
    return (m == 1) ? "strict" : "loose";
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_run[m] = 0; m_done[m] = 0; m_pass[m] = 0; m_idx[m] = 0; m_since[m] = 0;
      m_mc[m] = 0; m_cyc[m] = -1; m_fidx[m] = 0; m_fc[m] = 2'b00; m_fadr[m] = 0; m_fdata[m] = 0;
    end
  endtask

  task automatic model_start();
    for (int m = 0; m < 2; m++) begin
      m_idx[m] = 0; m_since[m] = 0;
      if (exp_q.size() == 0) begin
        m_done[m] = 1; m_pass[m] = 1; m_cyc[m] = 0;
      end else begin
        m_run[m] = 1;
      end
    end
  endtask

  task automatic model_fail(input int m, input int c, input logic [1:0] code,
                            input logic [31:0] a, input logic [31:0] d);
    m_run[m] = 0; m_done[m] = 1; m_pass[m] = 0; m_cyc[m] = c;
    m_fc[m] = code; m_fidx[m] = m_idx[m]; m_fadr[m] = a; m_fdata[m] = d;
  endtask

  // One clock edge of the run: walk the table in order.
  task automatic model_step(input int m, input int c, input bit mw,
                            input logic [31:0] a, input logic [31:0] d);
    logic [63:0] e;
    if (!m_run[m]) return;
    e = exp_q[m_idx[m]];
    if (mw && a == e[63:32] && d == e[31:0]) begin
      m_mc[m]++; m_idx[m]++; m_since[m] = 0;
      if (m_idx[m] == exp_q.size()) begin
        m_run[m] = 0; m_done[m] = 1; m_pass[m] = 1; m_cyc[m] = c;
      end
    end else if (mw && a == e[63:32]) model_fail(m, c, 2'b01, a, d);
    else if (mw && m == 1)            model_fail(m, c, 2'b10, a, d);
    else if (m_since[m] == TIMEOUT - 1) model_fail(m, c, 2'b11, 32'd0, 32'd0);
    else m_since[m]++;
  endtask

  task automatic sample(input int c);
    for (int m = 0; m < 2; m++)
      if (done_v[m] && d_cyc[m] < 0) d_cyc[m] = c;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    memwrite = 0; dataadr = 0; writedata = 0;
    exp_wr = 0; exp_adr = 0; exp_data = 0; start = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_now(input string cname);
    for (int m = 0; m < 2; m++) begin
      string t;
      t = {cname, "/", mname(m)};
      check({t, "/done"},  32'(done_v[m]), 32'(m_done[m]));
      check({t, "/pass"},  32'(pass_v[m]), 32'(m_pass[m]));
      check({t, "/code"},  32'(fc_v[m]), 32'(m_fc[m]));
      check({t, "/idx"},   32'(fidx_v[m]), 32'(m_fidx[m]));
      check({t, "/adr"},   fadr_v[m], m_fadr[m]);
      check({t, "/data"},  fdata_v[m], m_fdata[m]);
      check({t, "/match"}, 32'(mc_v[m]), 32'(m_mc[m]));
      check({t, "/ovf"},   32'(ovf_v[m]), 32'(m_ovf));
      check({t, "/count"}, 32'(cnt_v[m]), 32'(exp_q.size()));
      check({t, "/state"}, 32'(st_v[m]),
            !m_done[m] ? (m_run[m] ? 32'(RUN) : 32'(IDLE)) : (m_pass[m] ? 32'(PASS) : 32'(FAIL)));
    end
  endtask

  task automatic run_case(input string cname, input bit do_rst, input bit sim_start);
    int c;
    if (do_rst) apply_reset();
    check_now({cname, "/reset"});
    d_cyc[0] = -1; d_cyc[1] = -1;
    // load phase, with stray stores that IDLE must ignore
    foreach (load_q[i]) begin
      exp_wr = 1; exp_adr = load_q[i][63:32]; exp_data = load_q[i][31:0];
      memwrite = 1'($urandom_range(0, 1)); dataadr = $urandom; writedata = $urandom;
      start = sim_start && (i == load_q.size() - 1);
      @(posedge clk);
      if (exp_q.size() < DEPTH) exp_q.push_back(load_q[i]); else m_ovf = 1;
      if (start) model_start();
      @(negedge clk);
    end
    if (!(sim_start && load_q.size() > 0)) begin
      drive_idle(); start = 1;
      @(posedge clk);
      model_start();
      @(negedge clk);
    end
    sample(0);
    drive_idle();
    c = 0;
    while (!(m_done[0] && m_done[1]) && c < MAXC) begin
      c++;
      if (st_q.size() > 0) {memwrite, dataadr, writedata} = st_q.pop_front();
      else begin memwrite = 0; dataadr = 0; writedata = 0; end
      exp_wr = ($urandom_range(0, 9) == 0); exp_adr = $urandom; exp_data = $urandom;
      start  = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      for (int m = 0; m < 2; m++) model_step(m, c, memwrite, dataadr, writedata);
      @(negedge clk);
      sample(c);
    end
    check({cname, "/budget"}, 32'(c < MAXC), 32'd1);
    // activity after the verdict must change nothing
    for (int k = 1; k <= 3; k++) begin
      memwrite = 1; dataadr = $urandom; writedata = $urandom;
      exp_wr = 1; exp_adr = $urandom; exp_data = $urandom; start = 1;
      @(posedge clk);
      @(negedge clk);
      sample(c + k);
    end
    drive_idle();
    check_now({cname, "/final"});
    for (int m = 0; m < 2; m++)
      check({cname, "/", mname(m), "/cycle"}, 32'(d_cyc[m]), 32'(m_cyc[m]));
    load_q.delete();
    st_q.delete();
  endtask

  task automatic gen_random(input int n);
    logic [63:0] e;
    int ne;
    for (int i = 0; i < n; i++)
      load_q.push_back({32'h80 + 32'($urandom_range(0, 15)) * 4, 32'($urandom)});
    ne = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < ne; i++) begin
      int r;
      e = load_q[i];
      r = $urandom_range(0, 99);
      if (r < 6)       st_q.push_back({1'b1, 32'h400 + 32'($urandom_range(0, 63)) * 4, 32'($urandom)});
      else if (r < 10) st_q.push_back({1'b1, e[63:32], e[31:0] ^ (32'd1 << $urandom_range(0, 31))});
      else if (r < 13) for (int k = 0; k < 18; k++) st_q.push_back(65'd0);
      for (int k = $urandom_range(0, 2); k > 0; k--) st_q.push_back(65'd0);
      st_q.push_back({1'b1, e});
    end
  endtask

  task automatic mid_reset();
    apply_reset();
    foreach (load_q[i]) begin
      @(negedge clk);
    end
    exp_wr = 1; exp_adr = 32'd80; exp_data = 32'd5;
    @(posedge clk); @(negedge clk);
    exp_adr = 32'd84; exp_data = 32'd7;
    @(posedge clk); @(negedge clk);
    drive_idle(); start = 1;
    @(posedge clk); @(negedge clk);
    drive_idle(); memwrite = 1; dataadr = 32'd80; writedata = 32'd5;
    @(posedge clk); @(negedge clk);
    drive_idle();
    check("midrst/strict/match1", 32'(mc_v[1]), 32'd1);
    check("midrst/loose/match1",  32'(mc_v[0]), 32'd1);
    reset = 1;
    @(posedge clk); @(negedge clk);
    reset = 0;
    model_reset();
    check_now("midrst/after");
    load_q = '{{32'd80, 32'd5}, {32'd84, 32'd7}};
    st_q   = '{{1'b1, 32'd80, 32'd5}, {1'b1, 32'd84, 32'd7}};
    run_case("midrst/reload", 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    model_reset();

    load_q = '{{32'd80, 32'hFFFFFFFA}};
    st_q   = '{{1'b1, 32'd80, 32'hFFFFFFFA}};
    run_case("single_pass", 1'b1, 1'b0);

    load_q = '{{32'd80, 32'hFFFFFFFA}};
    st_q   = '{{1'b1, 32'd84, 32'h7}};
    run_case("wrong_adr", 1'b1, 1'b0);

    load_q = '{{32'd80, 32'hFFFFFFFA}};
    st_q   = '{{1'b1, 32'd80, 32'h000000FA}};
    run_case("bad_data", 1'b1, 1'b0);

    load_q = '{{32'd80, 32'd5}, {32'd84, 32'd7}};
    st_q   = '{{1'b1, 32'd96, 32'd1}, {1'b1, 32'd80, 32'd5}, {1'b1, 32'd100, 32'd2}, {1'b1, 32'd84, 32'd7}};
    run_case("skip_other", 1'b1, 1'b0);

    load_q = '{{32'd80, 32'd5}};
    run_case("timeout", 1'b1, 1'b0);

    // match on the very edge the timer would expire
    load_q = '{{32'd80, 32'd5}};
    for (int k = 0; k < TIMEOUT - 1; k++) st_q.push_back(65'd0);
    st_q.push_back({1'b1, 32'd80, 32'd5});
    run_case("match_at_limit", 1'b1, 1'b0);

    run_case("empty_table", 1'b1, 1'b0);

    load_q = '{{32'd80, 32'd5}, {32'd84, 32'd6}};
    st_q   = '{{1'b1, 32'd80, 32'd5}, {1'b1, 32'd84, 32'd6}};
    run_case("load_with_start", 1'b1, 1'b1);

    for (int i = 0; i <= DEPTH; i++) load_q.push_back({32'h100 + 32'(i) * 4, 32'(i) + 32'h55});
    for (int i = 0; i < DEPTH; i++) st_q.push_back({1'b1, 32'h100 + 32'(i) * 4, 32'(i) + 32'h55});
    run_case("overflow", 1'b1, 1'b0);

    mid_reset();

    for (int t = 0; t < 24; t++) begin
      gen_random($urandom_range(0, DEPTH + 1));
      run_case($sformatf("rand%0d", t), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_stream_checker.md
Name: store_stream_checker

Overview:
- Synthesizable monitor that sits directly downstream of the MIPS single-cycle `top`.
- Consumes its data-memory write stream (memwrite, dataadr, writedata) and compares each store against a preloaded table of expected (address, data) pairs.
- Reports pass/fail, with the failing entry captured, so directed programs (lb/lh/sb/sh, arithmetic) are self-checking in simulation and on FPGA.

Parameters:
- DEPTH, 8, number of expected-store entries held in the table (power of two, ≥ 2).
- TIMEOUT, 1024, maximum cycles in RUN without a matching store before declaring failure.
- STRICT, 1, 1 = any store not matching the next entry fails; 0 = stores to other addresses are ignored.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears table, counters and verdict.
- memwrite  in  1  data-memory write enable from `top`.
- dataadr  in  32  data-memory byte address from `top`.
- writedata  in  32  store data from `top`.
- exp_wr  in  1  load one expected entry (honoured only in IDLE).
- exp_adr  in  32  expected store address for the entry being loaded.
- exp_data  in  32  expected store data for the entry being loaded.
- start  in  1  single-cycle pulse; arms checking.
- done  out  1  verdict reached (PASS or FAIL).
- pass  out  1  valid when done; 1 = all entries matched.
- fail_code  out  2  00 none, 01 data mismatch, 10 wrong address (STRICT), 11 timeout.
- fail_idx  out  $clog2(DEPTH)  entry index at failure.
- fail_adr  out  32  dataadr captured at failure (0 for timeout).
- fail_data  out  32  writedata captured at failure (0 for timeout).
- match_cnt  out  $clog2(DEPTH)+1  entries matched so far.
- load_ovf  out  1  sticky; exp_wr attempted with table full.

Behaviour:
- Reset (synchronous): state=IDLE; entry count, idx, timer, match_cnt = 0; done=0, pass=0, fail_code=00, fail_idx=0, fail_adr=0, fail_data=0, load_ovf=0.
- Table contents need not be cleared on reset.
- Stores are sampled on the rising clk edge. The CPU holds memwrite, dataadr and writedata stable for the whole cycle.
- IDLE:
  - exp_wr with count<DEPTH writes entry[count] and increments count.
  - exp_wr with count==DEPTH is ignored and sets load_ovf.
  - memwrite is ignored.
  - exp_wr and start in the same cycle: the entry is written first, and start sees the incremented count.
  - start with count==0: go to PASS next cycle.
  - start with count>0: go to RUN next cycle, with idx=0 and timer=0.
- RUN, on each edge with memwrite=1:
  - dataadr==entry[idx].adr and writedata==entry[idx].data: match_cnt++, timer=0, idx++. If idx was count-1, go to PASS.
  - Address match but data mismatch: go to FAIL with code 01.
  - Address mismatch and STRICT=1: go to FAIL with code 10.
  - Address mismatch and STRICT=0: the store is ignored and the timer keeps counting.
- RUN, timer:
  - Increments every cycle without a match.
  - When timer reaches TIMEOUT-1 without a match: go to FAIL with code 11.
  - A match on that same cycle wins over the timeout.
- On any FAIL: capture fail_idx=idx, plus fail_adr and fail_data (both 0 for a timeout).
- PASS: done=1, pass=1.
- FAIL: done=1, pass=0.
- PASS and FAIL are terminal and hold until reset. Further memwrite, start and exp_wr are ignored; load_ovf does not change.
- Outputs are registered: the verdict appears the cycle after the deciding edge.
- Comparisons are exact 32-bit compares; no byte masking. Sub-word stores are checked as the full writedata word that `top` drives.
- Reset asserted mid-RUN aborts the run and returns to IDLE with an empty table. The table must be reloaded.

Decomposition:
- Package `checker_pkg`:
  - enum state_t {IDLE, RUN, PASS, FAIL}.
  - enum fail_code_t {FC_NONE=2'b00, FC_DATA=2'b01, FC_ADDR=2'b10, FC_TIMEOUT=2'b11}.
  - struct exp_entry_t {logic [31:0] adr; logic [31:0] data;}.
- One sub-module, `exp_table`:
  - DEPTH-entry register file of exp_entry_t.
  - Synchronous write, combinational read by idx; owns count and load_ovf.
- FSM, timer and capture registers live in store_stream_checker.

Test Plan:
- Load {(80, 32'hFFFFFFFA)}, start, one store adr=80 data=32'hFFFFFFFA -> done=1, pass=1, match_cnt=1 on the next cycle.
- Same table, STRICT=1, store adr=84 data=32'h7 -> done=1, pass=0, fail_code=10, fail_idx=0, fail_adr=84, fail_data=7.
- Same table, store adr=80 data=32'h000000FA -> fail_code=01, fail_data=32'h000000FA.
- STRICT=0, table {(80,5),(84,7)}, stores (96,1),(80,5),(100,2),(84,7) -> pass=1, match_cnt=2.
- TIMEOUT=16, table {(80,5)}, no stores after start -> done=1, fail_code=11, fail_idx=0, 16 cycles after RUN entry. Separately, DEPTH+1 exp_wr pulses -> load_ovf=1, count=DEPTH.
- Reset asserted for one cycle mid-RUN after 1 of 2 matches -> done=0, match_cnt=0, IDLE. After reload and start, pass is still reached.
